// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: load-use, branch, memory wait, overflow.
// Optional PIPE_CTRL_PERF_EN adds the Stall_cycles / Flush_events performance counters.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        Reset_n,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_uses_Rt,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_Rd,
  input  logic        EX_Branch_taken,
  input  logic        MEM_req,
  input  logic        MEM_ready,
  input  logic        MEM_Overflow,
  output logic        PC_en,
  output logic        IFID_en,
  output logic        IDEX_en,
  output logic        EXMEM_en,
  output logic        MEMWR_en,
  output logic        IFID_flush,
  output logic        IDEX_flush,
  output logic        EXMEM_flush,
  output logic        MEMWR_flush,
  output logic        Exc_take,
  output logic        Mem_timeout,
  output logic [1:0]  Ctrl_state,
  output logic [31:0] Stall_cycles,
  output logic [31:0] Flush_events
);

  typedef enum logic [1:0] {
    StRun      = 2'd0,
    StMemWait  = 2'd1,
    StExcDrain = 2'd2,
    StHalt     = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [8:0] wait_cnt_inc;
  logic       wait_expired;

  logic load_use, mem_wait, in_run;
  logic ev_ovf, ev_mem, ev_br, ev_lu;

  assign load_use = EX_MemRead && (EX_Rd != 5'd0) &&
                    ((EX_Rd == ID_Rs) || (ID_uses_Rt && (EX_Rd == ID_Rt)));
  assign mem_wait = MEM_req && !MEM_ready;
  assign in_run   = (state_q == StRun);

  // Priority: overflow > memory wait > branch > load-use; only the winner acts.
  assign ev_ovf = in_run && MEM_Overflow;
  assign ev_mem = in_run && !MEM_Overflow && mem_wait;
  assign ev_br  = in_run && !MEM_Overflow && !mem_wait && EX_Branch_taken;
  assign ev_lu  = in_run && !MEM_Overflow && !mem_wait && !EX_Branch_taken && load_use;

  assign wait_cnt_inc = {1'b0, wait_cnt_q} + 9'd1;
  assign wait_expired = (wait_cnt_inc == 9'(MEM_TIMEOUT));

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      StRun: begin
        if (ev_ovf) begin
          state_d = StExcDrain;
        end else if (ev_mem) begin
          state_d    = StMemWait;
          wait_cnt_d = 8'd0;
        end
      end
      StMemWait: begin
        if (MEM_ready) begin
          state_d    = StRun;
          wait_cnt_d = 8'd0;
        end else begin
          wait_cnt_d = wait_cnt_inc[7:0];
          if (wait_expired) state_d = StHalt;
        end
      end
      StExcDrain: state_d = StRun;
      StHalt:     state_d = StHalt;
      default:    state_d = StRun;
    endcase
  end

  // State moves on the falling edge, together with the pipeline registers it steers.
  always_ff @(negedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= StRun;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    PC_en       = 1'b1;
    IFID_en     = 1'b1;
    IDEX_en     = 1'b1;
    EXMEM_en    = 1'b1;
    MEMWR_en    = 1'b1;
    IFID_flush  = 1'b0;
    IDEX_flush  = 1'b0;
    EXMEM_flush = 1'b0;
    MEMWR_flush = 1'b0;
    Exc_take    = 1'b0;
    if (!Reset_n) begin
      PC_en       = 1'b0;
      IFID_en     = 1'b0;
      IDEX_en     = 1'b0;
      EXMEM_en    = 1'b0;
      MEMWR_en    = 1'b0;
      IFID_flush  = 1'b1;
      IDEX_flush  = 1'b1;
      EXMEM_flush = 1'b1;
      MEMWR_flush = 1'b1;
    end else begin
      unique case (state_q)
        StRun: begin
          if (ev_ovf) begin
            IFID_flush  = 1'b1;
            IDEX_flush  = 1'b1;
            EXMEM_flush = 1'b1;
            MEMWR_flush = 1'b1;
            Exc_take    = 1'b1;
          end else if (ev_mem) begin
            PC_en       = 1'b0;
            IFID_en     = 1'b0;
            IDEX_en     = 1'b0;
            EXMEM_en    = 1'b0;
            MEMWR_flush = 1'b1;
          end else if (ev_br) begin
            IFID_flush = 1'b1;
            IDEX_flush = 1'b1;
          end else if (ev_lu) begin
            PC_en      = 1'b0;
            IFID_en    = 1'b0;
            IDEX_flush = 1'b1;
          end
        end
        StMemWait: begin
          // Ready cycle falls through to plain RUN outputs so MEM/WB captures the data.
          if (!MEM_ready) begin
            PC_en       = 1'b0;
            IFID_en     = 1'b0;
            IDEX_en     = 1'b0;
            EXMEM_en    = 1'b0;
            MEMWR_flush = 1'b1;
          end
        end
        StExcDrain: begin
          IFID_flush = 1'b1;
          IDEX_flush = 1'b1;
        end
        StHalt: begin
          PC_en       = 1'b0;
          IFID_en     = 1'b0;
          IDEX_en     = 1'b0;
          EXMEM_en    = 1'b0;
          MEMWR_en    = 1'b0;
          IFID_flush  = 1'b1;
          IDEX_flush  = 1'b1;
          EXMEM_flush = 1'b1;
          MEMWR_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // HALT is only left through reset, so the state itself is the sticky flag.
  assign Mem_timeout = (state_q == StHalt);
  assign Ctrl_state  = state_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(negedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (!PC_en && (state_q != StHalt)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (ev_br || ev_ovf)               flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign Stall_cycles = stall_cnt_q;
  assign Flush_events = flush_cnt_q;
`else
  assign Stall_cycles = 32'd0;
  assign Flush_events = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors queue expectations, a monitor compares.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        Reset_n;
  logic [4:0]  ID_Rs, ID_Rt, EX_Rd;
  logic        ID_uses_Rt, EX_MemRead, EX_Branch_taken;
  logic        MEM_req, MEM_ready, MEM_Overflow;
  logic        PC_en, IFID_en, IDEX_en, EXMEM_en, MEMWR_en;
  logic        IFID_flush, IDEX_flush, EXMEM_flush, MEMWR_flush;
  logic        Exc_take, Mem_timeout;
  logic [1:0]  Ctrl_state;
  logic [31:0] Stall_cycles, Flush_events;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(15)) dut (
    .clk            (clk),
    .Reset_n        (Reset_n),
    .ID_Rs          (ID_Rs),
    .ID_Rt          (ID_Rt),
    .ID_uses_Rt     (ID_uses_Rt),
    .EX_MemRead     (EX_MemRead),
    .EX_Rd          (EX_Rd),
    .EX_Branch_taken(EX_Branch_taken),
    .MEM_req        (MEM_req),
    .MEM_ready      (MEM_ready),
    .MEM_Overflow   (MEM_Overflow),
    .PC_en          (PC_en),
    .IFID_en        (IFID_en),
    .IDEX_en        (IDEX_en),
    .EXMEM_en       (EXMEM_en),
    .MEMWR_en       (MEMWR_en),
    .IFID_flush     (IFID_flush),
    .IDEX_flush     (IDEX_flush),
    .EXMEM_flush    (EXMEM_flush),
    .MEMWR_flush    (MEMWR_flush),
    .Exc_take       (Exc_take),
    .Mem_timeout    (Mem_timeout),
    .Ctrl_state     (Ctrl_state),
    .Stall_cycles   (Stall_cycles),
    .Flush_events   (Flush_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PC,IFID,IDEX,EXMEM,MEMWR en | IFID,IDEX,EXMEM,MEMWR flush | Exc_take | Mem_timeout | state}
  localparam logic [12:0] EXP_RUN = 13'b11111_0000_0_0_00;
  localparam logic [12:0] EXP_RST = 13'b00000_1111_0_0_00;
  localparam logic [12:0] EXP_LU  = 13'b00111_0100_0_0_00;
  localparam logic [12:0] EXP_BR  = 13'b11111_1100_0_0_00;
  localparam logic [12:0] EXP_OVF = 13'b11111_1111_1_0_00;
  localparam logic [12:0] EXP_DRN = 13'b11111_1100_0_0_10;
  localparam logic [12:0] EXP_MWR = 13'b00001_0001_0_0_00;
  localparam logic [12:0] EXP_MW  = 13'b00001_0001_0_0_01;
  localparam logic [12:0] EXP_MWD = 13'b11111_0000_0_0_01;
  localparam logic [12:0] EXP_HLT = 13'b00000_1111_0_1_11;

  typedef struct {
    logic [12:0] vec;
    logic [31:0] stall;
    logic [31:0] flush;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_stall = 32'd0;
  logic [31:0] m_flush = 32'd0;
  logic [12:0] act_vec;

  assign act_vec = {PC_en, IFID_en, IDEX_en, EXMEM_en, MEMWR_en,
                    IFID_flush, IDEX_flush, EXMEM_flush, MEMWR_flush,
                    Exc_take, Mem_timeout, Ctrl_state};

  // Monitor: outputs are combinational, sampled mid-cycle on the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        n_cmp++;
        if (act_vec !== e.vec) begin
          n_bad++;
          $display("FAIL %s: outputs %b, expected %b", e.name, act_vec, e.vec);
        end
        n_cmp++;
        if (Stall_cycles !== e.stall || Flush_events !== e.flush) begin
          n_bad++;
          $display("FAIL %s_perf: stall %0d flush %0d, expected stall %0d flush %0d",
                   e.name, Stall_cycles, Flush_events, e.stall, e.flush);
        end
      end
    end
  end

  task automatic step(input string name, input logic rstn, input logic [4:0] rs,
                      input logic [4:0] rt, input logic urt, input logic mr,
                      input logic [4:0] rd, input logic br, input logic req,
                      input logic rdy, input logic ovf, input logic [12:0] vec);
    exp_t e;
    @(negedge clk);
    #1;
    Reset_n         = rstn;
    ID_Rs           = rs;
    ID_Rt           = rt;
    ID_uses_Rt      = urt;
    EX_MemRead      = mr;
    EX_Rd           = rd;
    EX_Branch_taken = br;
    MEM_req         = req;
    MEM_ready       = rdy;
    MEM_Overflow    = ovf;
`ifdef PIPE_CTRL_PERF_EN
    if (!rstn) begin
      m_stall = 32'd0;
      m_flush = 32'd0;
    end
`endif
    e.vec   = vec;
    e.stall = m_stall;
    e.flush = m_flush;
    e.name  = name;
    exp_q.push_back(e);
`ifdef PIPE_CTRL_PERF_EN
    if (rstn) begin
      if (!vec[12] && vec[1:0] != 2'd3) m_stall = m_stall + 32'd1;
      if (vec[3] || (vec[1:0] == 2'd0 && vec[7:4] == 4'b1100)) m_flush = m_flush + 32'd1;
    end
`endif
  endtask

  initial begin
    Reset_n = 1'b0; ID_Rs = '0; ID_Rt = '0; ID_uses_Rt = 1'b0; EX_MemRead = 1'b0;
    EX_Rd = '0; EX_Branch_taken = 1'b0; MEM_req = 1'b0; MEM_ready = 1'b0; MEM_Overflow = 1'b0;

    step("rst_hold0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, EXP_RST);
    step("rst_hold1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, EXP_RST);
    step("run_idle",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, EXP_RUN);

    // Load-use on Rs, then on Rt, then non-hazards
    step("lu_rs",     1, 5, 2, 0, 1, 5, 0, 0, 0, 0, EXP_LU);
    step("lu_rs_nxt", 1, 5, 2, 0, 0, 0, 0, 0, 0, 0, EXP_RUN);
    step("lu_rt",     1, 3, 7, 1, 1, 7, 0, 0, 0, 0, EXP_LU);
    step("lu_rt_nou", 1, 3, 7, 0, 1, 7, 0, 0, 0, 0, EXP_RUN);
    step("lu_rd0",    1, 0, 0, 1, 1, 0, 0, 0, 0, 0, EXP_RUN);

    // Branch wins over load-use
    step("br_lu",     1, 5, 0, 0, 1, 5, 1, 0, 0, 0, EXP_BR);
    step("br_after",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, EXP_RUN);

    // Zero-wait access, then 3 wait cycles with a deferred overflow inside
    step("mem_0wait", 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, EXP_RUN);
    step("mem_w1",    1, 0, 0, 0, 0, 0, 0, 1, 0, 0, EXP_MWR);
    step("mem_w2",    1, 0, 0, 0, 0, 0, 0, 1, 0, 1, EXP_MW);
    step("mem_w3",    1, 0, 0, 0, 0, 0, 0, 1, 0, 0, EXP_MW);
    step("mem_done",  1, 0, 0, 0, 0, 0, 0, 1, 1, 0, EXP_MWD);
    step("mem_after", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, EXP_RUN);

    // Memory wait outranks branch
    step("mem_br",    1, 0, 0, 0, 0, 0, 1, 1, 0, 0, EXP_MWR);
    step("mem_br_rd", 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, EXP_MWD);

    // Overflow with branch, drain ignores overflow
    step("ovf_br",    1, 0, 0, 0, 0, 0, 1, 0, 0, 1, EXP_OVF);
    step("ovf_drain", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, EXP_DRN);
    step("ovf_after", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, EXP_RUN);
    step("ovf_mem",   1, 0, 0, 0, 0, 0, 0, 1, 0, 1, EXP_OVF);
    step("ovf_drn2",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, EXP_DRN);

    // Reset in the middle of a wait (counter at 7)
    step("mw_rst_go", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, EXP_MWR);
    for (int i = 0; i < 7; i++) step("mw_rst_w", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, EXP_MW);
    step("mw_rst_a",  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, EXP_RST);
    step("mw_rst_b",  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, EXP_RST);
    step("mw_rst_rl", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, EXP_RUN);

    // Timeout: 15 wait cycles then HALT, ready no longer helps
    step("to_go",     1, 0, 0, 0, 0, 0, 0, 1, 0, 0, EXP_MWR);
    for (int i = 0; i < 15; i++) step("to_wait", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, EXP_MW);
    step("to_halt0",  1, 0, 0, 0, 0, 0, 0, 1, 0, 0, EXP_HLT);
    step("to_halt1",  1, 0, 0, 0, 0, 0, 0, 1, 1, 1, EXP_HLT);
    step("to_rst",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, EXP_RST);
    step("to_rel",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, EXP_RUN);
    step("to_lu",     1, 9, 0, 0, 1, 9, 0, 0, 0, 0, EXP_LU);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the five-stage MIPS pipeline. Drives the per-stage enable and synchronous-clear inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves four events in one priority order: load-use hazards, taken branches, data-memory wait states and arithmetic overflow. A small FSM with a wait counter sequences multi-cycle memory accesses and the exception drain, and latches a hard error if memory never responds.

## Interface
- MEM_TIMEOUT, 15, max consecutive MEM_WAIT cycles before entering HALT (1..255)
- clk  in  1  pipeline clock; all state updates on negedge clk, matching the pipeline registers
- Reset_n  in  1  asynchronous, active-low reset
- ID_Rs, ID_Rt  in  5 each  source registers of the instruction in ID
- ID_uses_Rt  in  1  instruction in ID reads Rt
- EX_MemRead  in  1  instruction in EX is a load
- EX_Rd  in  5  destination register of the instruction in EX
- EX_Branch_taken  in  1  branch resolved taken in EX
- MEM_req, MEM_ready  in  1 each  data-memory access in MEM / memory reports data valid
- MEM_Overflow  in  1  overflow flag carried by EX/MEM
- PC_en, IFID_en, IDEX_en, EXMEM_en, MEMWR_en  out  1 each  stage load enables
- IFID_flush, IDEX_flush, EXMEM_flush, MEMWR_flush  out  1 each  synchronous clear into the stage register (drives its Reset input)
- Exc_take  out  1  one-cycle pulse: load exception vector into PC
- Mem_timeout  out  1  sticky error flag
- Ctrl_state  out  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 EXC_DRAIN, 3 HALT
- Stall_cycles, Flush_events  out  32 each  performance counters (see Configuration)

## Operation
- Defaults in RUN: all enables are 1 and all flushes are 0.
- Event priority, highest first: overflow > memory wait > branch > load-use. Only the highest active event takes effect.
- Overflow (RUN, MEM_Overflow=1):
  - Assert IFID/IDEX/EXMEM/MEMWR flushes so the overflowed result is never written back.
  - Exc_take=1, PC_en=1.
  - Next state EXC_DRAIN.
- EXC_DRAIN (exactly 1 cycle):
  - IFID_flush=1, IDEX_flush=1, Exc_take=0, all enables 1.
  - Next state RUN. MEM_Overflow is ignored in this state.
- Memory wait (RUN, MEM_req=1, MEM_ready=0):
  - PC_en, IFID_en, IDEX_en and EXMEM_en all 0.
  - MEMWR_flush=1, so the bubble into WB has RegWr=0.
  - Wait counter is cleared. Next state MEM_WAIT.
- MEM_WAIT:
  - Same freeze outputs as memory wait; counter increments each cycle.
  - MEM_ready=1: normal RUN outputs that cycle, the MEM result is captured into MEM/WB, next state RUN.
  - Counter reaches MEM_TIMEOUT with no MEM_ready: next state HALT.
  - Overflow during MEM_WAIT is deferred until after RUN resumes.
- Branch taken (RUN): IFID_flush=1 and IDEX_flush=1; PC_en=1 so the target loads.
- Load-use (RUN): condition is EX_MemRead=1, EX_Rd≠0, and EX_Rd==ID_Rs or (ID_uses_Rt and EX_Rd==ID_Rt).
  - PC_en=0, IFID_en=0, IDEX_flush=1.
  - EX/MEM and MEM/WB advance normally.
- Branch and load-use in the same cycle: branch wins. The instruction in ID is squashed, so there is no stall.
- HALT: all enables 0, all flushes 1, Mem_timeout=1. The block stays in HALT until Reset_n is asserted.

## Timing
- Outputs are combinational from the current state and inputs. They are sampled by the pipeline registers at the same negedge that updates the FSM.
- Load-use costs exactly 1 bubble cycle. A taken branch costs 2 squashed slots. Overflow costs 2 flush cycles.
- A memory access with k wait cycles stalls for k cycles. MEM_ready on the first MEM_req cycle gives zero stall.
- Timeout: HALT is entered after MEM_TIMEOUT cycles in MEM_WAIT.
- Reset (Reset_n=0, asynchronous, any state including mid-MEM_WAIT):
  - Ctrl_state=0, wait counter=0, Mem_timeout=0, Exc_take=0.
  - All enables 0 and all flushes 1 while reset is held.
  - Normal RUN outputs from the first negedge after deassertion.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - Stall_cycles increments on every cycle in which PC_en=0 (not in HALT).
  - Flush_events increments once per branch or overflow event.
  - Both counters wrap at 2^32 and clear on reset.
- Not defined: both outputs are tied to 0 and no counter flops are generated.

## Test plan
- Load-use: lw with EX_Rd=5 in EX, ID_Rs=5 → one cycle of PC_en=0, IFID_en=0, IDEX_flush=1, then normal. Repeat with EX_Rd=0 → no stall.
- Branch plus load-use in the same cycle → IFID_flush=IDEX_flush=1, PC_en=1, no stall.
- MEM_req with MEM_ready low for 3 cycles → Ctrl_state=1 for 3 cycles, MEMWR_flush=1 each cycle, then RUN with one clean writeback. With PERF_EN, Stall_cycles=3.
- MEM_ready never asserted, MEM_TIMEOUT=15 → HALT after 15 wait cycles with Mem_timeout=1. Asserting Reset_n=0 → Ctrl_state=0 and Mem_timeout=0.
- MEM_Overflow=1 together with EX_Branch_taken=1 → Exc_take pulses 1 cycle, MEMWR_flush=1, then EXC_DRAIN for 1 cycle, then RUN.
- Reset_n asserted mid-MEM_WAIT (counter=7) → asynchronous return to RUN, counter=0, all flushes 1 until deassertion.
